// File: rtl/uart_baud_gen.sv
// Fractional baud tick generator: rx_tick at OVERSAMPLE x baud, tx_tick at baud.
// Optional one-second strobe on sec_tick when UART_SEC_TICK_EN is defined.
module uart_baud_gen #(
  parameter int unsigned CLK_FREQ   = 24_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              div_pend,
  output logic              rx_tick,
  output logic              tx_tick,
  output logic              sec_tick
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  localparam logic [63:0] DEF_D =
    (64'(CLK_FREQ) << FRAC_W) / (64'(BAUD) * 64'(OVERSAMPLE));

  localparam logic [DIV_W-1:0]  DEF_INT  = DEF_D[FRAC_W +: DIV_W];
  localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_D[FRAC_W-1:0];
  localparam logic [DIV_W:0]    DEF_CNT  =
    {1'b0, DEF_INT} - (DIV_W+1)'(1);

  logic [DIV_W-1:0]  int_a;
  logic [FRAC_W-1:0] frac_a;
  logic [DIV_W-1:0]  int_s;
  logic [FRAC_W-1:0] frac_s;
  logic [DIV_W:0]    cnt;
  logic [OS_W-1:0]   os;
  logic [FRAC_W-1:0] acc;

  logic [DIV_W-1:0]  wr_int;
  logic [FRAC_W:0]   acc_sum;
  logic              carry;
  logic              cnt_zero;
  logic              os_last;
  logic              bit_end;
  logic              apply;
  logic [DIV_W:0]    reload_a;
  logic [DIV_W:0]    reload_i;
  logic [DIV_W:0]    reload_s;

  assign wr_int   = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
  assign acc_sum  = {1'b0, acc} + {1'b0, frac_a};
  assign carry    = acc_sum[FRAC_W];
  assign cnt_zero = (cnt == '0);
  assign os_last  = (os == OS_W'(OVERSAMPLE - 1));
  assign bit_end  = en & cnt_zero & os_last;
  assign apply    = div_pend & (~en | bit_end);

  assign reload_i = {1'b0, int_a} - (DIV_W+1)'(1);
  assign reload_a = reload_i + (DIV_W+1)'(carry);
  assign reload_s = {1'b0, int_s} - (DIV_W+1)'(1);

  // Shadow takes writes any time; active only changes on a bit boundary or idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_a    <= DEF_INT;
      frac_a   <= DEF_FRAC;
      int_s    <= DEF_INT;
      frac_s   <= DEF_FRAC;
      div_pend <= 1'b0;
    end else begin
      if (apply) begin
        int_a  <= int_s;
        frac_a <= frac_s;
      end
      if (div_wr) begin
        int_s  <= wr_int;
        frac_s <= div_frac;
      end
      if (div_wr)
        div_pend <= 1'b1;
      else if (apply)
        div_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= DEF_CNT;
      os      <= '0;
      acc     <= '0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      unique case (1'b1)
        !en: begin
          cnt     <= apply ? reload_s : reload_i;
          os      <= '0;
          acc     <= '0;
          rx_tick <= 1'b0;
          tx_tick <= 1'b0;
        end
        cnt_zero: begin
          rx_tick <= 1'b1;
          tx_tick <= os_last;
          os      <= os_last ? '0 : os + OS_W'(1);
          // A newly applied divisor starts its first bit with a clean phase
          if (apply) begin
            acc <= '0;
            cnt <= reload_s;
          end else begin
            acc <= acc_sum[FRAC_W-1:0];
            cnt <= reload_a;
          end
        end
        default: begin
          cnt     <= cnt - (DIV_W+1)'(1);
          rx_tick <= 1'b0;
          tx_tick <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_SEC_TICK_EN
  logic [31:0] sec_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt  <= '0;
      sec_tick <= 1'b0;
    end else if (sec_cnt == 32'(CLK_FREQ - 1)) begin
      sec_cnt  <= '0;
      sec_tick <= 1'b1;
    end else begin
      sec_cnt  <= sec_cnt + 32'd1;
      sec_tick <= 1'b0;
    end
  end
`else
  assign sec_tick = 1'b0;
`endif

endmodule
